// File: rtl/afu_port_tx_guard.sv
`default_nettype none
// ============================================================================
// Module   : afu_port_tx_guard
// Purpose  : Per-port TX guard between an AFU TX stream and the PF/VF mux.
//            Forwards AXI-S beats through one output register. On a port
//            soft reset mid-packet it emits a synthetic tlast beat so the
//            mux never sees an open packet. While the port is held in reset
//            it sinks and discards upstream traffic. Counts truncated and
//            dropped packets (saturating, cleared only by rst_n).
// Options  : AFU_TX_GUARD_TIMEOUT_EN - mid-packet stall timeout that forces
//            a flush and sets the sticky timeout_err flag.
// Revision : 1.0 - initial release
// ============================================================================
module afu_port_tx_guard #(
  parameter int TDATA_WIDTH    = 512,
  parameter int TUSER_WIDTH    = 10,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     port_rst_n,
  input  logic                     s_tvalid,
  output logic                     s_tready,
  input  logic [TDATA_WIDTH-1:0]   s_tdata,
  input  logic [TDATA_WIDTH/8-1:0] s_tkeep,
  input  logic [TUSER_WIDTH-1:0]   s_tuser,
  input  logic                     s_tlast,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic [TDATA_WIDTH-1:0]   m_tdata,
  output logic [TDATA_WIDTH/8-1:0] m_tkeep,
  output logic [TUSER_WIDTH-1:0]   m_tuser,
  output logic                     m_tlast,
  output logic [15:0]              trunc_cnt,
  output logic [15:0]              drop_cnt,
  output logic                     timeout_err
);

  localparam int         c_KEEP_W   = TDATA_WIDTH / 8;
  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_PKT   = 2'd1;
  localparam logic [1:0] c_ST_FLUSH = 2'd2;
  localparam logic [1:0] c_ST_BLOCK = 2'd3;
  localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

  logic [1:0]             r_state;
  logic [1:0]             w_state_nxt;
  logic                   r_ovld;
  logic [TDATA_WIDTH-1:0] r_tdata;
  logic [c_KEEP_W-1:0]    r_tkeep;
  logic [TUSER_WIDTH-1:0] r_tuser;
  logic                   r_tlast;
  logic [15:0]            r_trunc_cnt;
  logic [15:0]            r_drop_cnt;
  logic                   r_drop_mid;

  logic w_load;
  logic w_s_tready;
  logic w_acc;
  logic w_pass_acc;
  logic w_blk_acc;
  logic w_flush_load;
  logic w_drop_mid_nxt;
  logic w_timeout;
  logic w_hold;

  // Output register can take a new beat when empty or being drained
  assign w_load       = !r_ovld || m_tready;
  assign w_acc        = s_tvalid && w_s_tready;
  assign w_pass_acc   = w_acc && ((r_state == c_ST_IDLE) || (r_state == c_ST_PKT));
  assign w_blk_acc    = w_acc && (r_state == c_ST_BLOCK);
  assign w_flush_load = (r_state == c_ST_FLUSH) && w_load;
  // drop_mid as it will be after this cycle, used for the BLOCK exit decision
  assign w_drop_mid_nxt = w_blk_acc ? !s_tlast : r_drop_mid;

  // Upstream ready: forward states gate on room and port state, BLOCK sinks all
  always_comb begin
    w_s_tready = 1'b0;
    case (r_state)
      c_ST_IDLE, c_ST_PKT: w_s_tready = w_load && port_rst_n;
      c_ST_FLUSH:          w_s_tready = 1'b0;
      default:             w_s_tready = 1'b1;
    endcase
  end

  // Nothing is accepted while the block itself is in reset
  assign s_tready = w_s_tready && rst_n;

`ifdef AFU_TX_GUARD_TIMEOUT_EN
  localparam int c_STALL_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_STALL_W-1:0] c_STALL_MAX = c_STALL_W'(TIMEOUT_CYCLES - 1);

  logic [c_STALL_W-1:0] r_stall;
  logic                 r_to_hold;
  logic                 r_timeout_err;
  logic                 w_stall_cyc;

  // A stall cycle: mid-packet, port up, room downstream, nothing arrived
  assign w_stall_cyc = (r_state == c_ST_PKT) && port_rst_n && !w_acc && w_load;
  assign w_timeout   = w_stall_cyc && (r_stall == c_STALL_MAX);
  // After a timeout the port must be cycled through reset before reuse
  assign w_hold      = r_to_hold;
  assign timeout_err = r_timeout_err;

  // Stall counter, sticky error flag and the post-timeout hold flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall       <= '0;
      r_to_hold     <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      if (w_stall_cyc) begin
        r_stall <= w_timeout ? '0 : r_stall + c_STALL_W'(1);
      end else if ((r_state != c_ST_PKT) || w_acc) begin
        r_stall <= '0;
      end
      if (w_timeout) begin
        r_timeout_err <= 1'b1;
        r_to_hold     <= 1'b1;
      end else if (!port_rst_n) begin
        r_to_hold     <= 1'b0;
      end
    end
  end
`else
  assign w_timeout   = 1'b0;
  assign w_hold      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Packet-boundary tracking state machine
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE: begin
        if (!port_rst_n)            w_state_nxt = c_ST_BLOCK;
        else if (w_acc && !s_tlast) w_state_nxt = c_ST_PKT;
      end
      c_ST_PKT: begin
        if (!port_rst_n || w_timeout) w_state_nxt = c_ST_FLUSH;
        else if (w_acc && s_tlast)    w_state_nxt = c_ST_IDLE;
      end
      c_ST_FLUSH: begin
        if (w_load) w_state_nxt = c_ST_BLOCK;
      end
      default: begin
        if (port_rst_n && !w_drop_mid_nxt && !w_hold) w_state_nxt = c_ST_IDLE;
      end
    endcase
  end

  // State and discard-side packet tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= c_ST_BLOCK;
      r_drop_mid <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_drop_mid <= w_drop_mid_nxt;
    end
  end

  // Output register: forwarded beat, synthetic close beat, or drain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovld  <= 1'b0;
      r_tdata <= '0;
      r_tkeep <= '0;
      r_tuser <= '0;
      r_tlast <= 1'b0;
    end else if (w_pass_acc) begin
      r_ovld  <= 1'b1;
      r_tdata <= s_tdata;
      r_tkeep <= s_tkeep;
      r_tuser <= s_tuser;
      r_tlast <= s_tlast;
    end else if (w_flush_load) begin
      r_ovld  <= 1'b1;
      r_tdata <= '0;
      r_tkeep <= '1;
      r_tuser <= '0;
      r_tlast <= 1'b1;
    end else if (m_tready) begin
      r_ovld  <= 1'b0;
    end
  end

  // Saturating truncation and drop counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_trunc_cnt <= '0;
      r_drop_cnt  <= '0;
    end else begin
      if (w_flush_load && (r_trunc_cnt != c_CNT_MAX)) r_trunc_cnt <= r_trunc_cnt + 16'd1;
      if (w_blk_acc && s_tlast && (r_drop_cnt != c_CNT_MAX)) r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign m_tvalid  = r_ovld;
  assign m_tdata   = r_tdata;
  assign m_tkeep   = r_tkeep;
  assign m_tuser   = r_tuser;
  assign m_tlast   = r_tlast;
  assign trunc_cnt = r_trunc_cnt;
  assign drop_cnt  = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_afu_port_tx_guard.sv
`default_nettype none
// ============================================================================
// Module   : tb_afu_port_tx_guard
// Purpose  : Self-checking bench for afu_port_tx_guard. A packet-level model
//            predicts the downstream beat stream (forwarded beats plus
//            synthetic close beats) and the truncate/drop counts.
// Options  : AFU_TX_GUARD_TIMEOUT_EN selects the expected timeout behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_afu_port_tx_guard;

  localparam int DW = 64;
  localparam int KW = DW / 8;
  localparam int UW = 10;
  localparam int TO = 16;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic [UW-1:0] u;
    logic          l;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n, port_rst_n;
  logic          s_tvalid, s_tready, s_tlast;
  logic [DW-1:0] s_tdata;
  logic [KW-1:0] s_tkeep;
  logic [UW-1:0] s_tuser;
  logic          m_tvalid, m_tready, m_tlast;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic [UW-1:0] m_tuser;
  logic [15:0]   trunc_cnt, drop_cnt;
  logic          timeout_err;

  int    checks = 0;
  int    errors = 0;
  beat_t exp_q[$];
  bit    bp_mode = 0;
  bit    in_pkt = 0, blocked = 0, mdl_drop_mid = 0;
  int    exp_trunc = 0, exp_drop = 0;
  bit    exp_to = 0;
  bit    held = 0;
  beat_t held_b;
  beat_t last_b;

  always #5 clk = ~clk;

  afu_port_tx_guard #(
    .TDATA_WIDTH(DW), .TUSER_WIDTH(UW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .port_rst_n(port_rst_n),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
    .s_tkeep(s_tkeep), .s_tuser(s_tuser), .s_tlast(s_tlast),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
    .m_tkeep(m_tkeep), .m_tuser(m_tuser), .m_tlast(m_tlast),
    .trunc_cnt(trunc_cnt), .drop_cnt(drop_cnt), .timeout_err(timeout_err)
  );

  // Downstream monitor: in-order scoreboard and AXI-S hold-stability check
  always @(negedge clk) begin
    beat_t obs;
    obs = {m_tdata, m_tkeep, m_tuser, m_tlast};
    if (rst_n !== 1'b1) begin
      held = 0;
    end else begin
      if (held) begin
        checks++;
        assert (m_tvalid === 1'b1 && obs === held_b) else begin
          errors++;
          $error("FAIL hold_stable observed=%0h/%0b expected=%0h/1", obs, m_tvalid, held_b);
        end
      end
      if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_beat observed=%0h expected=none", obs);
        end
        if (exp_q.size() != 0) begin
          checks++;
          assert (obs === exp_q[0]) else begin
            errors++;
            $error("FAIL out_beat observed=%0h expected=%0h", obs, exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
      end
      held   = (m_tvalid === 1'b1) && (m_tready === 1'b0);
      held_b = obs;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin
      if (bp_mode) m_tready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
  endtask

  function automatic beat_t rand_beat(input logic last);
    beat_t b;
    b.d = {$urandom, $urandom};
    b.k = 8'($urandom);
    b.u = 10'($urandom);
    b.l = last;
    return b;
  endfunction

  // Packet-level model of what an accepted upstream beat becomes
  function automatic void model_accept(input beat_t b);
    if (blocked) begin
      if (b.l) begin
        if (exp_drop < 65535) exp_drop++;
        mdl_drop_mid = 0;
        if (port_rst_n === 1'b1) blocked = 0;
      end else begin
        mdl_drop_mid = 1;
      end
    end else begin
      exp_q.push_back(b);
      in_pkt = !b.l;
    end
  endfunction

  task automatic send_beat(input beat_t b);
    bit done;
    int n;
    done = 0; n = 0;
    s_tvalid = 1'b1; s_tdata = b.d; s_tkeep = b.k; s_tuser = b.u; s_tlast = b.l;
    while (!done && n < 200) begin
      if (bp_mode) m_tready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (s_tready === 1'b1) begin
        model_accept(b);
        done = 1;
      end
      @(posedge clk); #1;
      n++;
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
    chk("accept_timeout", 64'(done), 64'd1);
    last_b = b;
  endtask

  task automatic port_down();
    beat_t syn;
    port_rst_n = 1'b0;
    if (in_pkt && !blocked) begin
      syn.d = '0; syn.k = '1; syn.u = '0; syn.l = 1'b1;
      exp_q.push_back(syn);
      exp_trunc++;
    end
    in_pkt  = 0;
    blocked = 1;
  endtask

  task automatic port_up();
    port_rst_n = 1'b1;
    if (!mdl_drop_mid) blocked = 0;
    wait_cycles(1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, cut;
    rst_n = 1'b0; port_rst_n = 1'b1; m_tready = 1'b1;
    s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0; s_tuser = '0; s_tlast = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_tvalid", 64'(m_tvalid), 0);
    chk("rst_m_tdata", m_tdata, 0);
    chk("rst_s_tready", 64'(s_tready), 0);
    chk("rst_trunc", 64'(trunc_cnt), 0);
    chk("rst_drop", 64'(drop_cnt), 0);
    chk("rst_timeout", 64'(timeout_err), 0);
    rst_n = 1'b1;
    wait_cycles(2);

    // T1: 4-beat packet back-to-back, 1-cycle latency, no bubbles
    for (int i = 0; i < 4; i++) begin
      send_beat(rand_beat(i == 3));
      chk("t1_latency_vld", 64'(m_tvalid), 1);
      chk("t1_latency_data", m_tdata, last_b.d);
    end
    wait_cycles(3);
    chk("t1_drain", 64'(exp_q.size()), 0);
    chk("t1_trunc", 64'(trunc_cnt), 0);
    chk("t1_drop", 64'(drop_cnt), 0);

    // T2: port reset after beat 2 of 4, then three packets discarded
    send_beat(rand_beat(1'b0));
    send_beat(rand_beat(1'b0));
    port_down();
    for (int p = 0; p < 3; p++) begin
      send_beat(rand_beat(1'b0));
      send_beat(rand_beat(1'b1));
    end
    wait_cycles(2);
    chk("t2_block_mvalid", 64'(m_tvalid), 0);
    chk("t2_drain", 64'(exp_q.size()), 0);
    chk("t2_trunc", 64'(trunc_cnt), 64'(exp_trunc));
    chk("t2_drop", 64'(drop_cnt), 64'(exp_drop));
    port_up();

    // T3: beat 2 held under backpressure when the port resets
    send_beat(rand_beat(1'b0));
    send_beat(rand_beat(1'b0));
    m_tready = 1'b0;
    port_down();
    wait_cycles(3);
    chk("t3_hold_vld", 64'(m_tvalid), 1);
    chk("t3_hold_data", m_tdata, last_b.d);
    chk("t3_flush_ready", 64'(s_tready), 0);
    m_tready = 1'b1;
    wait_cycles(4);
    chk("t3_drain", 64'(exp_q.size()), 0);
    chk("t3_trunc", 64'(trunc_cnt), 64'(exp_trunc));
    port_up();

    // T4: port released while a discarded packet is still open
    port_down();
    wait_cycles(2);
    send_beat(rand_beat(1'b0));
    port_up();
    send_beat(rand_beat(1'b0));
    send_beat(rand_beat(1'b1));
    send_beat(rand_beat(1'b0));
    send_beat(rand_beat(1'b1));
    wait_cycles(3);
    chk("t4_drain", 64'(exp_q.size()), 0);
    chk("t4_drop", 64'(drop_cnt), 64'(exp_drop));

    // Random traffic with backpressure and occasional mid-packet port resets
    bp_mode = 1;
    for (int p = 0; p < 10; p++) begin
      len = $urandom_range(1, 4);
      cut = (len > 1 && $urandom_range(0, 2) == 0) ? $urandom_range(1, len - 1) : 0;
      for (int j = 0; j < len; j++) begin
        if (cut != 0 && j == cut) begin
          port_down();
          wait_cycles(2);
        end
        send_beat(rand_beat(j == len - 1));
      end
      if (cut != 0) port_up();
    end
    bp_mode = 0; m_tready = 1'b1;
    wait_cycles(4);
    chk("rnd_drain", 64'(exp_q.size()), 0);
    chk("rnd_trunc", 64'(trunc_cnt), 64'(exp_trunc));
    chk("rnd_drop", 64'(drop_cnt), 64'(exp_drop));

    // Mid-packet upstream stall
    send_beat(rand_beat(1'b0));
`ifdef AFU_TX_GUARD_TIMEOUT_EN
    port_down();
    port_rst_n = 1'b1;
    exp_to = 1;
    wait_cycles(TO + 6);
    chk("to_drain", 64'(exp_q.size()), 0);
    chk("to_flag", 64'(timeout_err), 64'(exp_to));
    chk("to_trunc", 64'(trunc_cnt), 64'(exp_trunc));
    port_down();
    wait_cycles(2);
    port_up();
`else
    wait_cycles(TO + 6);
    chk("to_no_flush", 64'(m_tvalid), 0);
    chk("to_flag", 64'(timeout_err), 64'(exp_to));
    chk("to_trunc", 64'(trunc_cnt), 64'(exp_trunc));
    send_beat(rand_beat(1'b1));
`endif
    send_beat(rand_beat(1'b1));
    wait_cycles(3);
    chk("to_after_drain", 64'(exp_q.size()), 0);

    // drop_cnt saturation: 65540 single-beat packets discarded
    port_down();
    wait_cycles(2);
    s_tvalid = 1'b1; s_tlast = 1'b1; s_tdata = {$urandom, $urandom};
    repeat (65540) @(posedge clk);
    #1;
    s_tvalid = 1'b0; s_tlast = 1'b0;
    exp_drop = (exp_drop + 65540 > 65535) ? 65535 : exp_drop + 65540;
    chk("sat_drop", 64'(drop_cnt), 64'(exp_drop));
    port_up();

    // rst_n asserted mid-packet: immediate clear, no synthetic beat
    m_tready = 1'b0;
    send_beat(rand_beat(1'b0));
    rst_n = 1'b0;
    #1;
    chk("arst_mvalid", 64'(m_tvalid), 0);
    chk("arst_sready", 64'(s_tready), 0);
    chk("arst_trunc", 64'(trunc_cnt), 0);
    chk("arst_drop", 64'(drop_cnt), 0);
    exp_q.delete();
    in_pkt = 0; blocked = 0; mdl_drop_mid = 0; exp_trunc = 0; exp_drop = 0;
    m_tready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_cycles(3);
    chk("arst_no_synth", 64'(m_tvalid), 0);
    send_beat(rand_beat(1'b1));
    wait_cycles(3);
    chk("arst_drain", 64'(exp_q.size()), 0);
    chk("arst_trunc_end", 64'(trunc_cnt), 64'(exp_trunc));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
